// File: rtl/bcomp_sig_tester.sv
// Stimulus/response tester for the locked bcomp controller: LFSR-driven condition
// inputs, MISR compaction of the returned outputs, and golden-signature verdict.
module bcomp_sig_tester #(
    parameter int unsigned NUM_VEC    = 256,
    parameter int unsigned RST_CYC    = 4,
    parameter logic [17:0] LFSR_SEED  = 18'h00001,
    parameter logic [38:0] GOLDEN_SIG = 39'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        key_in,
    output logic [17:0] x_out,
    output logic        key_out,
    output logic        dut_rst,
    input  logic [38:0] y_in,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [38:0] signature
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_RESET_DUT = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    // An all-zero seed would lock the LFSR up, so it is replaced by 1.
    localparam logic [17:0] SEED     = (LFSR_SEED == 18'h00000) ? 18'h00001 : LFSR_SEED;
    localparam logic [15:0] VEC_LAST = 16'((NUM_VEC == 32'd0) ? 32'd0 : (NUM_VEC - 32'd1));
    localparam logic [7:0]  RST_LAST = 8'((RST_CYC == 32'd0) ? 32'd0 : (RST_CYC - 32'd1));
    localparam logic        HAS_VEC  = (NUM_VEC != 32'd0);

    function automatic logic [17:0] lfsr_step(input logic [17:0] cur);
        return {cur[16:0], cur[17] ^ cur[10]};
    endfunction

    function automatic logic [38:0] misr_step(input logic [38:0] cur, input logic [38:0] din);
        logic [38:0] nxt;
        nxt[0] = cur[38] ^ cur[34] ^ din[0];
        for (int i = 1; i < 39; i++) begin
            nxt[i] = cur[i-1] ^ din[i];
        end
        return nxt;
    endfunction

    logic [1:0]  state_q,   state_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic [15:0] vec_cnt_q, vec_cnt_d;
    logic [17:0] x_q,       x_d;
    logic        key_q,     key_d;
    logic        dut_rst_q, dut_rst_d;
    logic        busy_q,    busy_d;
    logic        done_q,    done_d;
    logic        pass_q,    pass_d;
    logic [38:0] misr_q,    misr_d;
    logic [38:0] misr_abs_s;

    // MISR value after absorbing the current controller response.
    always_comb begin
        misr_abs_s = misr_step(misr_q, y_in);
    end

    // Next-state and next-output computation for the run sequencer.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        vec_cnt_d = vec_cnt_q;
        x_d       = x_q;
        key_d     = key_q;
        dut_rst_d = dut_rst_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        misr_d    = misr_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_RESET_DUT;
                    key_d     = key_in;
                    misr_d    = 39'h0;
                    rst_cnt_d = 8'd0;
                    vec_cnt_d = 16'd0;
                    x_d       = 18'h00000;
                    dut_rst_d = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_RESET_DUT: begin
                if (rst_cnt_q == RST_LAST) begin
                    if (HAS_VEC) begin
                        state_d   = S_RUN;
                        x_d       = SEED;
                        dut_rst_d = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (misr_q == GOLDEN_SIG);
                    end
                end else begin
                    rst_cnt_d = rst_cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                // y_in seen at this edge belongs to the x_out held during the cycle just ending.
                misr_d    = misr_abs_s;
                vec_cnt_d = vec_cnt_q + 16'd1;
                if (vec_cnt_q == VEC_LAST) begin
                    state_d   = S_DONE;
                    x_d       = 18'h00000;
                    dut_rst_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pass_d    = (misr_abs_s == GOLDEN_SIG);
                end else begin
                    x_d = lfsr_step(x_q);
                end
            end
            default: begin
                state_d   = S_IDLE;
                rst_cnt_d = 8'd0;
                vec_cnt_d = 16'd0;
                x_d       = 18'h00000;
                key_d     = 1'b0;
                dut_rst_d = 1'b1;
                busy_d    = 1'b0;
                done_d    = 1'b0;
                pass_d    = 1'b0;
                misr_d    = 39'h0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rst_cnt_q <= 8'd0;
            vec_cnt_q <= 16'd0;
            x_q       <= 18'h00000;
            key_q     <= 1'b0;
            dut_rst_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            misr_q    <= 39'h0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            vec_cnt_q <= vec_cnt_d;
            x_q       <= x_d;
            key_q     <= key_d;
            dut_rst_q <= dut_rst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            misr_q    <= misr_d;
        end
    end

    assign x_out     = x_q;
    assign key_out   = key_q;
    assign dut_rst   = dut_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;

endmodule

// File: tb/tb_bcomp_sig_tester.sv
// Bench for bcomp_sig_tester: directed boundary runs on small instances plus
// randomized/loopback runs checked against a sequence-level model.
module tb_bcomp_sig_tester;

    localparam int          DN    = 40;
    localparam int          DR    = 3;
    localparam logic [17:0] DSEED = 18'h2ACE5;

    function automatic logic [17:0] lfsr_next(input logic [17:0] v);
        return {v[16:0], v[17] ^ v[10]};
    endfunction

    function automatic logic [38:0] misr_next(input logic [38:0] m, input logic [38:0] y);
        logic fb;
        fb = m[38] ^ m[34];
        return {m[37:0], 1'b0} ^ y ^ {38'h0, fb};
    endfunction

    // Stand-in for the locked controller: key bit flips a pattern into the response.
    function automatic logic [38:0] ctrl_model(input logic [17:0] x, input logic k);
        return {x[2:0], x, x ^ (k ? 18'h3C3C3 : 18'h00000)};
    endfunction

    function automatic logic [38:0] golden_of(input logic [17:0] seed, input int n, input logic k);
        logic [38:0] m;
        logic [17:0] x;
        m = 39'h0;
        x = seed;
        for (int i = 0; i < n; i++) begin
            m = misr_next(m, ctrl_model(x, k));
            x = lfsr_next(x);
        end
        return m;
    endfunction

    localparam logic [38:0] D_GOLD = golden_of(DSEED, DN, 1'b1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 1'b0, key_a = 1'b0;
    logic [38:0] y_a = 39'h0;
    logic [17:0] x_a;
    logic        keyo_a, drst_a, busy_a, done_a, pass_a;
    logic [38:0] sig_a;

    logic        start_b = 1'b0, key_b = 1'b0;
    logic [38:0] y_b = 39'h0;
    logic [17:0] x_b;
    logic        keyo_b, drst_b, busy_b, done_b, pass_b;
    logic [38:0] sig_b;

    logic        start_c = 1'b0, key_c = 1'b0;
    logic [38:0] y_c = 39'h0;
    logic [17:0] x_c;
    logic        keyo_c, drst_c, busy_c, done_c, pass_c;
    logic [38:0] sig_c;

    logic        start_d = 1'b0, key_d = 1'b0, loop_d = 1'b0;
    logic [38:0] yr_d = 39'h0;
    logic [38:0] y_d;
    logic [17:0] x_d;
    logic        keyo_d, drst_d, busy_d, done_d, pass_d;
    logic [38:0] sig_d;

    assign y_d = loop_d ? ctrl_model(x_d, keyo_d) : yr_d;

    bcomp_sig_tester #(.NUM_VEC(4), .RST_CYC(2), .LFSR_SEED(18'h00001), .GOLDEN_SIG(39'h0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .key_in(key_a), .x_out(x_a), .key_out(keyo_a),
        .dut_rst(drst_a), .y_in(y_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));

    bcomp_sig_tester #(.NUM_VEC(2), .RST_CYC(1), .LFSR_SEED(18'h00000), .GOLDEN_SIG(39'h0)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .key_in(key_b), .x_out(x_b), .key_out(keyo_b),
        .dut_rst(drst_b), .y_in(y_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));

    bcomp_sig_tester #(.NUM_VEC(0), .RST_CYC(3), .LFSR_SEED(18'h00001), .GOLDEN_SIG(39'h5)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .key_in(key_c), .x_out(x_c), .key_out(keyo_c),
        .dut_rst(drst_c), .y_in(y_c), .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c));

    bcomp_sig_tester #(.NUM_VEC(DN), .RST_CYC(DR), .LFSR_SEED(DSEED), .GOLDEN_SIG(D_GOLD)) u_d (
        .clk(clk), .rst(rst), .start(start_d), .key_in(key_d), .x_out(x_d), .key_out(keyo_d),
        .dut_rst(drst_d), .y_in(y_d), .busy(busy_d), .done(done_d), .pass(pass_d), .signature(sig_d));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_b(input string tag, input logic [38:0] hit, input logic [38:0] exp_sig);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        check_eq({tag, "_x_seed"}, 64'(x_b), 64'h1);
        y_b = hit;
        tick();
        check_eq({tag, "_done_early"}, 64'(done_b), 64'h0);
        y_b = 39'h0;
        tick();
        check_eq({tag, "_done"}, 64'(done_b), 64'h1);
        check_eq({tag, "_sig"}, 64'(sig_b), 64'(exp_sig));
        check_eq({tag, "_pass"}, 64'(pass_b), 64'(exp_sig == 39'h0));
    endtask

    task automatic run_d(input logic k, input bit loop, input bit pulse, input bit abort,
                         output logic [38:0] sig_seen);
        logic [17:0] exp_x;
        logic [38:0] exp_sig;
        logic [38:0] yv;
        logic [63:0] r;
        bit          aborted;
        aborted  = 1'b0;
        sig_seen = 39'h0;
        key_d    = k;
        loop_d   = loop;
        start_d  = 1'b1;
        tick();
        start_d  = 1'b0;
        exp_x    = DSEED;
        exp_sig  = 39'h0;
        for (int c = 0; c <= DR + DN; c++) begin
            if (c < DR) begin
                check_eq("d_rst_phase", {62'h0, busy_d, drst_d}, 64'h3);
            end
            if (c >= DR && c < DR + DN) begin
                check_eq("d_x", {45'h0, drst_d, x_d}, {46'h0, exp_x});
                r  = {$urandom(), $urandom()};
                yv = loop ? ctrl_model(exp_x, k) : r[38:0];
                yr_d    = yv;
                exp_sig = misr_next(exp_sig, yv);
                exp_x   = lfsr_next(exp_x);
            end
            if (c == DR + DN - 1) begin
                check_eq("d_done_early", 64'(done_d), 64'h0);
            end
            if (pulse && c == DR + 5) begin
                start_d = 1'b1;
                key_d   = ~k;
            end else begin
                start_d = 1'b0;
            end
            if (abort && c == DR + 7) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check_eq("d_abort_state", {61'h0, busy_d, done_d, drst_d}, 64'h1);
                check_eq("d_abort_sig", 64'(sig_d), 64'h0);
                aborted = 1'b1;
                break;
            end
            if (c < DR + DN) begin
                tick();
            end
        end
        if (!aborted) begin
            check_eq("d_done", {61'h0, done_d, busy_d, drst_d}, 64'h5);
            check_eq("d_x_done", 64'(x_d), 64'h0);
            check_eq("d_key", 64'(keyo_d), 64'(k));
            check_eq("d_sig", 64'(sig_d), 64'(exp_sig));
            check_eq("d_pass", 64'(pass_d), 64'(exp_sig == D_GOLD));
            sig_seen = sig_d;
        end
        key_d = k;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] exp_xa [4];
        logic [38:0] s_ref, s_tmp;
        exp_xa = '{18'h00001, 18'h00002, 18'h00004, 18'h00008};

        // Reset held with start asserted.
        rst = 1'b1;
        start_a = 1'b1; start_b = 1'b1; start_c = 1'b1; start_d = 1'b1;
        key_a = 1'b1; key_d = 1'b1;
        tick(); tick(); tick();
        check_eq("rst_x", 64'(x_a), 64'h0);
        check_eq("rst_key", 64'(keyo_a), 64'h0);
        check_eq("rst_dut_rst", 64'(drst_a), 64'h1);
        check_eq("rst_flags", {61'h0, busy_a, done_a, pass_a}, 64'h0);
        check_eq("rst_sig", 64'(sig_a), 64'h0);
        check_eq("rst_busy_d", 64'(busy_d), 64'h0);
        rst = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
        key_a = 1'b0; key_d = 1'b0;
        tick();
        check_eq("idle_after_rst", {61'h0, busy_a, done_a, drst_a}, 64'h1);

        // LFSR sequence on the 4-vector instance.
        key_a = 1'b1;
        y_a   = 39'h0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check_eq("a_key_latched", 64'(keyo_a), 64'h1);
        check_eq("a_dut_rst_hold", 64'(drst_a), 64'h1);
        tick();
        check_eq("a_busy", 64'(busy_a), 64'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("a_x_seq", {45'h0, drst_a, x_a}, {46'h0, exp_xa[i]});
            check_eq("a_not_done", 64'(done_a), 64'h0);
        end
        tick();
        check_eq("a_done", {62'h0, done_a, busy_a}, 64'h2);
        check_eq("a_x_done", {45'h0, drst_a, x_a}, 64'h40000);
        check_eq("a_sig", 64'(sig_a), 64'h0);
        check_eq("a_pass", 64'(pass_a), 64'h1);

        // Single-bit MISR hits.
        run_b("b_hit0", 39'h1, 39'h2);
        run_b("b_hit38", 39'h4000000000, 39'h1);

        // Zero-length run.
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        tick();
        tick();
        check_eq("c_done_early", 64'(done_c), 64'h0);
        tick();
        check_eq("c_done", 64'(done_c), 64'h1);
        check_eq("c_sig", 64'(sig_c), 64'h0);
        check_eq("c_pass", 64'(pass_c), 64'h0);
        check_eq("c_x_rst", {45'h0, drst_c, x_c}, 64'h40000);

        // Loopback runs: reference, start glitch, abort/restart, wrong key.
        run_d(1'b1, 1'b1, 1'b0, 1'b0, s_ref);
        check_eq("d_good_key_pass", 64'(pass_d), 64'h1);
        run_d(1'b1, 1'b1, 1'b1, 1'b0, s_tmp);
        check_eq("d_pulse_same_sig", 64'(s_tmp), 64'(s_ref));
        run_d(1'b1, 1'b1, 1'b0, 1'b1, s_tmp);
        run_d(1'b1, 1'b1, 1'b0, 1'b0, s_tmp);
        check_eq("d_restart_same_sig", 64'(s_tmp), 64'(s_ref));
        run_d(1'b0, 1'b1, 1'b0, 1'b0, s_tmp);
        check_eq("d_bad_key_pass", 64'(pass_d), 64'h0);

        // Random responses.
        for (int n = 0; n < 3; n++) begin
            run_d(1'($urandom_range(1, 0)), 1'b0, 1'($urandom_range(1, 0)), 1'b0, s_tmp);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
